// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control path: opcodes, datapath select codes,
// state numbering and the packed control bundle driven toward the datapath.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEM_ADDR = 4'd2;
   localparam state_t S_MEM_RD   = 4'd3;
   localparam state_t S_MEM_WB   = 4'd4;
   localparam state_t S_MEM_WR   = 4'd5;
   localparam state_t S_R_EXEC   = 4'd6;
   localparam state_t S_R_WB     = 4'd7;
   localparam state_t S_BRANCH   = 4'd8;
   localparam state_t S_JUMP     = 4'd9;
   localparam state_t S_ADDI_EX  = 4'd10;
   localparam state_t S_ADDI_WB  = 4'd11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mcfsm_counters.sv
// Bring-up counters: retired instructions and free-running cycles since reset.
// Both wrap silently; no latency beyond the counting edge, no backpressure.
module mcfsm_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
         cycle_count <= '0;
      end else begin
         cycle_count <= cycle_count + CNT_W'(1);
         if (instr_done)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS32 sequencer: Moore-decoded datapath controls, 3-5 cycles per instruction.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; all controls held low while in reset.
module multicycle_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);
   import mips_ctrl_pkg::*;

   state_t cur_state;
   state_t nxt_state;
   ctrl_t  raw;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cur_state <= S_FETCH;
      else
         cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = S_FETCH;
      case (cur_state)
         S_FETCH:    nxt_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     nxt_state = S_R_EXEC;
               OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_J:         nxt_state = S_JUMP;
               OP_ADDI:      nxt_state = S_ADDI_EX;
               default:      nxt_state = S_FETCH;
            endcase
         end
         S_MEM_ADDR: nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   nxt_state = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   nxt_state = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   nxt_state = S_R_WB;
         S_ADDI_EX:  nxt_state = S_ADDI_WB;
         default:    nxt_state = S_FETCH;
      endcase
   end

   // Only FETCH's IR/PC load and MEM_WR's retire look at mem_ready; the rest is pure Moore.
   always_comb begin
      raw = '0;
      case (cur_state)
         S_FETCH: begin
            raw.mem_read  = 1'b1;
            raw.alu_src_b = SRCB_FOUR;
            raw.alu_op    = ALUOP_ADD;
            raw.pc_source = PCSRC_ALU;
            raw.ir_write  = mem_ready;
            raw.pc_write  = mem_ready;
         end
         S_DECODE: begin
            raw.alu_src_b  = SRCB_IMM_SH2;
            raw.alu_op     = ALUOP_ADD;
            raw.illegal_op = !is_legal_op(opcode);
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            raw.alu_src_a = 1'b1;
            raw.alu_src_b = SRCB_IMM;
            raw.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            raw.mem_read = 1'b1;
            raw.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            raw.reg_write  = 1'b1;
            raw.mem_to_reg = 1'b1;
            raw.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            raw.mem_write  = 1'b1;
            raw.i_or_d     = 1'b1;
            raw.instr_done = mem_ready;
         end
         S_R_EXEC: begin
            raw.alu_src_a = 1'b1;
            raw.alu_src_b = SRCB_RT;
            raw.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            raw.reg_write  = 1'b1;
            raw.reg_dst    = 1'b1;
            raw.instr_done = 1'b1;
         end
         S_BRANCH: begin
            raw.alu_src_a     = 1'b1;
            raw.alu_src_b     = SRCB_RT;
            raw.alu_op        = ALUOP_SUB;
            raw.pc_write_cond = 1'b1;
            raw.pc_source     = PCSRC_ALUOUT;
            raw.instr_done    = 1'b1;
         end
         S_JUMP: begin
            raw.pc_write   = 1'b1;
            raw.pc_source  = PCSRC_JUMP;
            raw.instr_done = 1'b1;
         end
         S_ADDI_WB: begin
            raw.reg_write  = 1'b1;
            raw.instr_done = 1'b1;
         end
         default: raw = '0;
      endcase
   end

   // Gate with reset so a write in flight is dropped the moment rst_n falls.
   assign ctrl = rst_n ? raw : '0;

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign instr_done    = ctrl.instr_done;
   assign illegal_op    = ctrl.illegal_op;
   assign state         = cur_state;

   mcfsm_counters #(.CNT_W(CNT_W)) u_counters (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_done  (ctrl.instr_done),
      .instr_count (instr_count),
      .cycle_count (cycle_count)
   );

endmodule
